dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter in front of a single-ported data memory. Port 0 is the
//   CPU, port 1 is the debug/DMA path. Each grant lasts exactly one cycle and
//   a port is never granted twice in a row, so a waiting port always gets the
//   next slot.
//
// Configuration macro
//   DMEM_ARB_RR_EN  defined   : a tie seen in IDLE goes to the port that was
//                               not served last (round-robin).
//                   undefined : a tie seen in IDLE always goes to port 0.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req0/1, we0/1              request and write strobe per port
//   addr0/1, wdata0/1          byte address and write data per port
//   ack0/1                     high for the single cycle the port is served
//   rdata0/1                   read data, forced to 0 when not acked
//   mem_we, mem_addr,
//   mem_datain                 memory command (registered)
//   mem_dataout                combinational read data from the memory
//   gcnt0/1                    completed grant counters, wrap at 2^CW
//
// state  | meaning
// IDLE   | no transaction on the memory bus
// SERVE0 | port 0 owns the memory for this cycle
// SERVE1 | port 1 owns the memory for this cycle

module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_datain,
   input  logic [DW-1:0] mem_dataout,
   output logic [CW-1:0] gcnt0,
   output logic [CW-1:0] gcnt1
);

`ifdef DMEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   state_t tie_pick;
   logic   last;     // 0 = port 0 served most recently, 1 = port 1

   // With round-robin off, last is still tracked but never steers the tie.
   always_comb begin
      tie_pick = (RR_EN && !last) ? SERVE1 : SERVE0;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: begin
            if (req0 && req1)
               state_nxt = tie_pick;
            else if (req0)
               state_nxt = SERVE0;
            else if (req1)
               state_nxt = SERVE1;
            else
               state_nxt = IDLE;
         end
         // A served port always yields for one cycle, so only the other
         // requester can follow directly.
         SERVE0:  state_nxt = req1 ? SERVE1 : IDLE;
         SERVE1:  state_nxt = req0 ? SERVE0 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state. Requesters hold their
   // command stable through the ack cycle, so capturing it at the grant edge
   // gives the same values as a combinational pass-through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         gcnt0      <= '0;
         gcnt1      <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_datain <= '0;
      end else begin
         state <= state_nxt;

         case (state_nxt)
            SERVE0: begin
               ack0       <= 1'b1;
               ack1       <= 1'b0;
               mem_we     <= we0;
               mem_addr   <= addr0;
               mem_datain <= wdata0;
            end
            SERVE1: begin
               ack0       <= 1'b0;
               ack1       <= 1'b1;
               mem_we     <= we1;
               mem_addr   <= addr1;
               mem_datain <= wdata1;
            end
            default: begin
               ack0       <= 1'b0;
               ack1       <= 1'b0;
               mem_we     <= 1'b0;
               mem_addr   <= '0;
               mem_datain <= '0;
            end
         endcase

         // Grant completes at the edge that ends the SERVE cycle.
         if (state == SERVE0) begin
            gcnt0 <= gcnt0 + 1'b1;
            last  <= 1'b0;
         end else if (state == SERVE1) begin
            gcnt1 <= gcnt1 + 1'b1;
            last  <= 1'b1;
         end
      end
   end

   // ack mirrors the SERVE state, so it doubles as the read-data select.
   assign rdata0 = ack0 ? mem_dataout : '0;
   assign rdata1 = ack1 ? mem_dataout : '0;

endmodule
